data_sram_slave: RTL

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

---
 rtl/data_sram_slave.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_sram_slave.sv
// Single-ported word SRAM behind a request/response handshake.
// Requests are accepted while fewer than QDEPTH responses are outstanding.
// Responses come back strictly in order, no sooner than LATENCY cycles after
// acceptance. Reads snapshot the memory word at acceptance. That value is
// carried through a small in-order queue until its data_ok cycle.
module data_sram_slave #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        resp_stall
);

  localparam int PTR_W     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(QDEPTH);
  localparam logic [PTR_W:0]   ONE_COUNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);
  localparam logic [3:0]       LAT_SAT    = 4'(LATENCY);
  localparam logic [3:0]       LAT_READY  = 4'(LATENCY - 1);

  // Storage
  logic [31:0] mem [0:MEM_DEPTH-1];
  logic [31:0] q_data [0:QDEPTH-1];
  logic        q_is_read [0:QDEPTH-1];
  logic [QDEPTH-1:0][3:0] age_vec;

  // Queue bookkeeping
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  // Registered RAM read and the queue slot it still has to be written into
  logic [31:0]      rd_word_reg;
  logic             capture_pending_reg;
  logic [PTR_W-1:0] capture_slot_reg;

  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        byte_mask;
  logic              accept;
  logic              head_valid;
  logic [31:0]       head_data;
  logic              unused_addr;

  assign word_idx    = addr[ADDR_W+1:2];
  assign unused_addr = ^addr[31:ADDR_W+2];

  // Byte lanes touched by a write; misaligned addresses are used as given
  always_comb begin
    byte_mask = 4'b1111;
    case (size)
      2'd0:    byte_mask = 4'b0001 << addr[1:0];
      2'd1:    byte_mask = addr[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  // Acceptance ignores a same-cycle pop so that a full queue stays closed
  assign addr_ok    = !reset && (count_reg < FULL_COUNT);
  assign accept     = req && addr_ok;
  assign head_valid = (count_reg != '0);
  assign data_ok    = !reset && head_valid && (age_vec[head_reg] >= LAT_READY) && !resp_stall;

  // A read accepted last cycle has its word in rd_word_reg, not yet in the queue
  assign head_data = (capture_pending_reg && (capture_slot_reg == head_reg)) ?
                     rd_word_reg : q_data[head_reg];
  assign rdata     = (data_ok && q_is_read[head_reg]) ? head_data : 32'h0;

  // RAM: byte-masked write, registered full-word read (pre-write value)
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) begin
          mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (accept && !wr) begin
      rd_word_reg <= mem[word_idx];
    end
  end

  // Head/tail pointers, occupancy and pending read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg            <= '0;
      tail_reg            <= '0;
      count_reg           <= '0;
      capture_pending_reg <= 1'b0;
      capture_slot_reg    <= '0;
    end else begin
      if (accept) begin
        tail_reg <= tail_reg + ONE_PTR;
      end
      if (data_ok) begin
        head_reg <= head_reg + ONE_PTR;
      end
      case ({accept, data_ok})
        2'b10:   count_reg <= count_reg + ONE_COUNT;
        2'b01:   count_reg <= count_reg - ONE_COUNT;
        default: count_reg <= count_reg;
      endcase
      capture_pending_reg <= accept && !wr;
      capture_slot_reg    <= tail_reg;
    end
  end

  // Queue payload: entry kind on acceptance, read word one cycle later
  always_ff @(posedge clk) begin
    if (accept) begin
      q_is_read[tail_reg] <= !wr;
    end
    if (capture_pending_reg) begin
      q_data[capture_slot_reg] <= rd_word_reg;
    end
  end

  // Per-slot age counters, restarted on enqueue and saturating at LATENCY
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_age
      logic [3:0] age_reg;

      // Age tracking for slot gi
      always_ff @(posedge clk) begin
        if (reset) begin
          age_reg <= 4'd0;
        end else if (accept && (tail_reg == PTR_W'(gi))) begin
          age_reg <= 4'd0;
        end else if (age_reg < LAT_SAT) begin
          age_reg <= age_reg + 4'd1;
        end
      end

      assign age_vec[gi] = age_reg;
    end
  endgenerate

endmodule
